ones_checksum_checker: RTL and testbench

Streaming receiver-side verifier for 4-bit-word ones'-complement checksums, the counterpart of the ones'-complement adder used on the generator side. It accepts a packet one word per cycle over a valid/ready handshake, with the transmitted checksum as the final word. It accumulates the words with end-around carry. After the last word it reports pass/fail, the final sum and the word count. It sits between the lab's packet source and the status/LED logic.

---
 rtl/ones_checksum_checker.sv | 146 ++++++++++++++
 tb/tb_ones_checksum_checker.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/ones_checksum_checker.sv
// ones_checksum_checker: receive-side ones'-complement checksum verifier.
// Latency: a LAST word accepted at edge N gives DONE plus the report in the following cycle.
// Backpressure: READY drops for the single REPORT cycle, so packets are separated by one bubble.
//
// Ports:
//   clk, rst_n          clock and asynchronous active-low reset
//   DIN/VALID/LAST      word stream in; LAST marks the checksum word
//   READY               word accepted on an edge where VALID && READY
//   DONE                one-cycle pulse; the report outputs are valid in this cycle
//   SUM/LEN/ERR/PASS    final sum, saturated word count, overflow flag, verdict.
//                       These hold their values until the next DONE.
module ones_checksum_checker #(
  parameter int WIDTH     = 4,
  parameter int MAX_WORDS = 15
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [WIDTH-1:0]                 DIN,
  input  logic                             VALID,
  input  logic                             LAST,
  output logic                             READY,
  output logic                             DONE,
  output logic                             PASS,
  output logic                             ERR,
  output logic [WIDTH-1:0]                 SUM,
  output logic [$clog2(MAX_WORDS+1)-1:0]   LEN
);

  localparam int CW = $clog2(MAX_WORDS + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_WORDS);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    REPORT = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  acc_q, acc_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic [CW-1:0]     len_q, len_d;
  logic              err_q, err_d;
  logic              pass_q, pass_d;
  logic              ready_q, ready_d;
  logic              done_q, done_d;

  logic              accept;
  logic [WIDTH:0]    add_t;
  logic [WIDTH-1:0]  acc_add;
  logic [CW-1:0]     cnt_inc;
  logic              ovf_inc;

  always_comb begin
    accept  = VALID && (state_q != REPORT);
    add_t   = {1'b0, acc_q} + {1'b0, DIN};
    // The end-around carry is folded back into the low bits. This second add
    // cannot carry out, because the low bits are at most 2^WIDTH-2 whenever
    // the carry is set.
    acc_add = add_t[WIDTH-1:0] + {{(WIDTH-1){1'b0}}, add_t[WIDTH]};
    cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
    ovf_inc = ovf_q | (cnt_q == CNT_MAX);

    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    sum_d   = sum_q;
    len_d   = len_q;
    err_d   = err_q;
    pass_d  = pass_q;

    case (state_q)
      IDLE, ACCUM: begin
        if (accept) begin
          acc_d = acc_add;
          cnt_d = cnt_inc;
          ovf_d = ovf_inc;
          if (LAST) begin
            // The report is loaded from the post-accept values, so it is
            // valid in the same cycle that DONE is high.
            state_d = REPORT;
            sum_d   = acc_add;
            len_d   = cnt_inc;
            err_d   = ovf_inc;
            pass_d  = (acc_add == {WIDTH{1'b1}}) && !ovf_inc;
          end else begin
            state_d = ACCUM;
          end
        end
      end
      REPORT: begin
        state_d = IDLE;
        acc_d   = '0;
        cnt_d   = '0;
        ovf_d   = 1'b0;
      end
      default: begin
        state_d = IDLE;
        acc_d   = '0;
        cnt_d   = '0;
        ovf_d   = 1'b0;
      end
    endcase

    // The handshake outputs are registered from the next state, so READY and
    // DONE are clean flop outputs.
    ready_d = (state_d != REPORT);
    done_d  = (state_d == REPORT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      sum_q   <= '0;
      len_q   <= '0;
      err_q   <= 1'b0;
      pass_q  <= 1'b0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      sum_q   <= sum_d;
      len_q   <= len_d;
      err_q   <= err_d;
      pass_q  <= pass_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end

  assign READY = ready_q;
  assign DONE  = done_q;
  assign SUM   = sum_q;
  assign LEN   = len_q;
  assign ERR   = err_q;
  assign PASS  = pass_q;

endmodule

// File: tb/tb_ones_checksum_checker.sv
// Testbench for ones_checksum_checker (WIDTH=4, MAX_WORDS=15).
// It runs directed packet vectors, randomised packets against an arithmetic
// reference model, and hand-written sequences for back-to-back packets and reset.
module tb_ones_checksum_checker;

  logic       clk;
  logic       rst_n;
  logic [3:0] DIN;
  logic       VALID;
  logic       LAST;
  logic       READY;
  logic       DONE;
  logic       PASS;
  logic       ERR;
  logic [3:0] SUM;
  logic [3:0] LEN;

  int checks = 0;
  int errors = 0;

  logic [3:0] pkt[$];

  typedef struct {
    string       name;
    int          n;
    logic [63:0] words;   // word i is at bits [4*i +: 4]
    int          exp_sum;
    int          exp_pass;
    int          exp_err;
    int          exp_len;
  } vec_t;

  vec_t vecs[6];

  ones_checksum_checker #(.WIDTH(4), .MAX_WORDS(15)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .DIN   (DIN),
    .VALID (VALID),
    .LAST  (LAST),
    .READY (READY),
    .DONE  (DONE),
    .PASS  (PASS),
    .ERR   (ERR),
    .SUM   (SUM),
    .LEN   (LEN)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  // Reference: a ones'-complement sum of 4-bit words is the ordinary integer
  // sum reduced mod 15. The result is 0 only when every word is 0; otherwise
  // it lies in the range 1..15.
  task automatic model(output int s_out, output int pass_out,
                       output int err_out, output int len_out);
    int s = 0;
    foreach (pkt[i]) s += int'(pkt[i]);
    s_out    = (s == 0) ? 0 : ((s - 1) % 15) + 1;
    err_out  = (pkt.size() > 15) ? 1 : 0;
    len_out  = (pkt.size() > 15) ? 15 : pkt.size();
    pass_out = (s_out == 15 && err_out == 0) ? 1 : 0;
  endtask

  // Sends pkt with up to max_gap idle cycles before each word, then checks
  // the DONE cycle and the cycle after it.
  task automatic run_packet(input string nm, input int max_gap,
                            input int e_sum, input int e_pass,
                            input int e_err, input int e_len);
    int n = pkt.size();
    for (int i = 0; i < n; i++) begin
      int g = (max_gap > 0) ? $urandom_range(max_gap, 0) : 0;
      for (int k = 0; k < g; k++) begin
        @(negedge clk);
        VALID = 1'b0; LAST = 1'b0; DIN = 4'($urandom);
      end
      @(negedge clk);
      if (i == 0) chk({nm, "_ready_start"}, int'(READY), 1);
      DIN = pkt[i]; VALID = 1'b1; LAST = (i == n - 1);
    end
    @(negedge clk);
    VALID = 1'b0; LAST = 1'b0;
    chk({nm, "_done"},  int'(DONE),  1);
    chk({nm, "_ready"}, int'(READY), 0);
    chk({nm, "_sum"},   int'(SUM),   e_sum);
    chk({nm, "_pass"},  int'(PASS),  e_pass);
    chk({nm, "_err"},   int'(ERR),   e_err);
    chk({nm, "_len"},   int'(LEN),   e_len);
    @(negedge clk);
    chk({nm, "_done_pulse"}, int'(DONE),  0);
    chk({nm, "_ready_back"}, int'(READY), 1);
    chk({nm, "_sum_hold"},   int'(SUM),   e_sum);
  endtask

  initial begin
    int e_sum, e_pass, e_err, e_len;

    vecs[0] = '{"basic",    3,  64'h375, 15, 1, 0, 3};
    vecs[1] = '{"eac",      3,  64'hC6C, 15, 1, 0, 3};
    vecs[2] = '{"corrupt",  3,  64'h725, 14, 0, 0, 3};
    vecs[3] = '{"one_f",    1,  64'hF,   15, 1, 0, 1};
    vecs[4] = '{"one_zero", 1,  64'h0,   0,  0, 0, 1};
    vecs[5] = '{"overflow", 16, 64'h0,   0,  0, 1, 15};

    DIN = 4'h0; VALID = 1'b0; LAST = 1'b0; rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready", int'(READY), 1);
    chk("rst_done",  int'(DONE),  0);
    chk("rst_pass",  int'(PASS),  0);
    chk("rst_err",   int'(ERR),   0);
    chk("rst_sum",   int'(SUM),   0);
    chk("rst_len",   int'(LEN),   0);
    rst_n = 1'b1;

    // Directed vectors
    for (int v = 0; v < 6; v++) begin
      pkt.delete();
      for (int i = 0; i < vecs[v].n; i++) begin
        logic [63:0] w;
        w = vecs[v].words;
        pkt.push_back(w[4*i +: 4]);
      end
      run_packet(vecs[v].name, 0, vecs[v].exp_sum, vecs[v].exp_pass,
                 vecs[v].exp_err, vecs[v].exp_len);
    end

    // Randomised packets, some closed with a correct checksum word
    for (int p = 0; p < 40; p++) begin
      int n = $urandom_range(18, 1);
      int s = 0;
      pkt.delete();
      for (int i = 0; i < n - 1; i++) begin
        pkt.push_back(4'($urandom));
        s += int'(pkt[i]);
      end
      if ($urandom_range(2, 0) == 0) begin
        int r = (s == 0) ? 0 : ((s - 1) % 15) + 1;
        pkt.push_back(4'(~r));
      end else begin
        pkt.push_back(4'($urandom));
      end
      model(e_sum, e_pass, e_err, e_len);
      run_packet($sformatf("rand%0d", p), 2, e_sum, e_pass, e_err, e_len);
    end

    // Back-to-back with VALID held high. The word offered during REPORT
    // (0100) must be rejected.
    @(negedge clk); DIN = 4'h5; VALID = 1'b1; LAST = 1'b0;
    @(negedge clk); DIN = 4'h3;
    @(negedge clk); DIN = 4'h7; LAST = 1'b1;
    @(negedge clk);
    chk("b2b_a_done",  int'(DONE),  1);
    chk("b2b_a_ready", int'(READY), 0);
    chk("b2b_a_sum",   int'(SUM),   15);
    chk("b2b_a_len",   int'(LEN),   3);
    DIN = 4'h4; LAST = 1'b0;
    @(negedge clk);
    chk("b2b_bubble_done",  int'(DONE),  0);
    chk("b2b_bubble_ready", int'(READY), 1);
    DIN = 4'h1;
    @(negedge clk); DIN = 4'h2; LAST = 1'b1;
    @(negedge clk);
    VALID = 1'b0; LAST = 1'b0;
    chk("b2b_b_done", int'(DONE), 1);
    chk("b2b_b_sum",  int'(SUM),  3);
    chk("b2b_b_len",  int'(LEN),  2);
    chk("b2b_b_pass", int'(PASS), 0);
    @(negedge clk);

    // Reset in the middle of a packet
    @(negedge clk); DIN = 4'h9; VALID = 1'b1; LAST = 1'b0;
    @(negedge clk); DIN = 4'h9;
    @(negedge clk); VALID = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_sum",   int'(SUM),   0);
    chk("mid_rst_len",   int'(LEN),   0);
    chk("mid_rst_done",  int'(DONE),  0);
    chk("mid_rst_pass",  int'(PASS),  0);
    chk("mid_rst_err",   int'(ERR),   0);
    chk("mid_rst_ready", int'(READY), 1);
    @(negedge clk); rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("mid_rst_no_done%0d", c), int'(DONE), 0);
    end
    pkt.delete();
    pkt.push_back(4'hF);
    run_packet("after_rst", 0, 15, 1, 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
